// File: rtl/muldiv_unit.sv
// Multi-cycle MUL/MULHU/DIVU/REMU responder (shift-add / restoring); `define MULDIV_SIGNED_EN adds MULH/DIV/REM.
// Latency: resp_valid DATA_WIDTH cycles after accept; unsupported op, divide-by-zero and overflow answer at accept.
// Backpressure: one op in flight; req_ready stays low until the response is taken with resp_ready.
module muldiv_unit #(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [OPCODE_LENGTH-1:0] req_op,
   input  logic [DATA_WIDTH-1:0]    req_a,
   input  logic [DATA_WIDTH-1:0]    req_b,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [DATA_WIDTH-1:0]    resp_result,
   output logic                     resp_err
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W + 1);

   localparam logic [OPCODE_LENGTH-1:0] OP_MUL   = OPCODE_LENGTH'(4'b1010);
   localparam logic [OPCODE_LENGTH-1:0] OP_MULHU = OPCODE_LENGTH'(4'b1011);
   localparam logic [OPCODE_LENGTH-1:0] OP_DIVU  = OPCODE_LENGTH'(4'b1100);
   localparam logic [OPCODE_LENGTH-1:0] OP_REMU  = OPCODE_LENGTH'(4'b1101);
`ifdef MULDIV_SIGNED_EN
   localparam logic [OPCODE_LENGTH-1:0] OP_MULH  = OPCODE_LENGTH'(4'b1110);
   localparam logic [OPCODE_LENGTH-1:0] OP_DIV   = OPCODE_LENGTH'(4'b0110);
   localparam logic [OPCODE_LENGTH-1:0] OP_REM   = OPCODE_LENGTH'(4'b0111);
`endif
   localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t         state;
   logic [CW-1:0]  count;
   logic [W-1:0]   hi;        // product high half / partial remainder
   logic [W-1:0]   lo;        // multiplier bits / dividend-then-quotient bits
   logic [W-1:0]   opnd;      // multiplicand or divisor magnitude
   logic           mode_mul;
   logic           want_hi;
   logic           want_rem;
   logic           neg_res;

   logic           dec_ok, dec_mul, dec_hi, dec_rem, dec_sgn;
   logic           a_neg, b_neg, b_zero, ovf;
   logic [W-1:0]   a_mag, b_mag;

   logic [W:0]     mul_sum, div_shift, div_diff;
   logic [W-1:0]   hi_n, lo_n, div_sel, fin;
   logic [2*W-1:0] prod;

   assign req_ready = (state == IDLE) && !reset;

   always_comb begin
      dec_ok  = 1'b1;
      dec_mul = 1'b0;
      dec_hi  = 1'b0;
      dec_rem = 1'b0;
      dec_sgn = 1'b0;
      case (req_op)
         OP_MUL:   dec_mul = 1'b1;
         OP_MULHU: begin dec_mul = 1'b1; dec_hi = 1'b1; end
         OP_DIVU:  begin end
         OP_REMU:  dec_rem = 1'b1;
`ifdef MULDIV_SIGNED_EN
         OP_MULH:  begin dec_mul = 1'b1; dec_hi = 1'b1; dec_sgn = 1'b1; end
         OP_DIV:   dec_sgn = 1'b1;
         OP_REM:   begin dec_rem = 1'b1; dec_sgn = 1'b1; end
`endif
         default:  dec_ok = 1'b0;
      endcase
   end

   // Signed ops iterate on magnitudes; -2^(W-1) maps onto itself, which is the right unsigned value.
   assign a_neg  = dec_sgn & req_a[W-1];
   assign b_neg  = dec_sgn & req_b[W-1];
   assign a_mag  = a_neg ? -req_a : req_a;
   assign b_mag  = b_neg ? -req_b : req_b;
   assign b_zero = (req_b == '0);
   assign ovf    = dec_sgn && !dec_mul && (req_a == MIN_NEG) && (req_b == '1);

   always_comb begin
      mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
      div_shift = {hi, lo[W-1]};
      div_diff  = div_shift - {1'b0, opnd};
      if (mode_mul) begin
         hi_n = mul_sum[W:1];
         lo_n = {mul_sum[0], lo[W-1:1]};
      end else if (!div_diff[W]) begin
         hi_n = div_diff[W-1:0];
         lo_n = {lo[W-2:0], 1'b1};
      end else begin
         hi_n = div_shift[W-1:0];
         lo_n = {lo[W-2:0], 1'b0};
      end
   end

   // Sign fix-up applied to the value produced by the last iteration.
   always_comb begin
      prod    = neg_res ? -{hi_n, lo_n} : {hi_n, lo_n};
      div_sel = want_rem ? hi_n : lo_n;
      if (mode_mul)
         fin = want_hi ? prod[2*W-1:W] : prod[W-1:0];
      else
         fin = neg_res ? -div_sel : div_sel;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         count       <= '0;
         resp_valid  <= 1'b0;
         resp_result <= '0;
         resp_err    <= 1'b0;
         hi          <= '0;
         lo          <= '0;
         opnd        <= '0;
         mode_mul    <= 1'b0;
         want_hi     <= 1'b0;
         want_rem    <= 1'b0;
         neg_res     <= 1'b0;
      end else if (flush) begin
         state       <= IDLE;
         count       <= '0;
         resp_valid  <= 1'b0;
         resp_result <= '0;
         resp_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  mode_mul <= dec_mul;
                  want_hi  <= dec_hi;
                  want_rem <= dec_rem;
                  neg_res  <= dec_rem ? a_neg : (a_neg ^ b_neg);
                  hi       <= '0;
                  lo       <= dec_mul ? b_mag : a_mag;
                  opnd     <= dec_mul ? a_mag : b_mag;
                  resp_err <= 1'b0;
                  if (!dec_ok) begin
                     state       <= DONE;
                     resp_valid  <= 1'b1;
                     resp_result <= '0;
                     resp_err    <= 1'b1;
                  end else if (!dec_mul && b_zero) begin
                     state       <= DONE;
                     resp_valid  <= 1'b1;
                     resp_result <= dec_rem ? req_a : '1;
                  end else if (ovf) begin
                     state       <= DONE;
                     resp_valid  <= 1'b1;
                     resp_result <= dec_rem ? '0 : req_a;
                  end else begin
                     state <= BUSY;
                     count <= CW'(W);
                  end
               end
            end
            BUSY: begin
               hi    <= hi_n;
               lo    <= lo_n;
               count <= count - CW'(1);
               if (count == CW'(1)) begin
                  state       <= DONE;
                  resp_valid  <= 1'b1;
                  resp_result <= fin;
               end
            end
            DONE: begin
               if (resp_ready) begin
                  state      <= IDLE;
                  resp_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboarded bench for muldiv_unit at DATA_WIDTH=32; signed vectors follow MULDIV_SIGNED_EN.
`timescale 1ns/1ps
module tb_muldiv_unit;
   localparam int W = 32;

   localparam logic [3:0] MUL   = 4'b1010;
   localparam logic [3:0] MULHU = 4'b1011;
   localparam logic [3:0] DIVU  = 4'b1100;
   localparam logic [3:0] REMU  = 4'b1101;
   localparam logic [3:0] MULH  = 4'b1110;
   localparam logic [3:0] DIV   = 4'b0110;
   localparam logic [3:0] REM   = 4'b0111;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         flush = 1'b0;
   logic         req_valid = 1'b0;
   logic         resp_ready = 1'b1;
   logic [3:0]   req_op = 4'b0000;
   logic [W-1:0] req_a = '0;
   logic [W-1:0] req_b = '0;
   logic         req_ready, resp_valid, resp_err;
   logic [W-1:0] resp_result;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   // Latency is counted in clock edges after the accept edge.
   typedef struct packed {
      logic [W-1:0] res;
      logic         err;
      logic [7:0]   lat;
      logic [31:0]  acc;
   } exp_t;
   exp_t sb[$];
   bit   seen = 1'b0;

   typedef struct packed {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         err;
      logic [7:0]   lat;
   } vec_t;

   localparam int NBASE = 15;
   vec_t base_tab [NBASE] = '{
      '{MUL,     32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 1'b0, 8'd32},
      '{MUL,     32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 1'b0, 8'd32},
      '{MUL,     32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 1'b0, 8'd32},
      '{MUL,     32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 8'd32},
      '{MULHU,   32'h8000_0000, 32'h0000_0004, 32'h0000_0002, 1'b0, 8'd32},
      '{DIVU,    32'd100,       32'd7,         32'd14,        1'b0, 8'd32},
      '{REMU,    32'd100,       32'd7,         32'd2,         1'b0, 8'd32},
      '{DIVU,    32'd7,         32'd100,       32'd0,         1'b0, 8'd32},
      '{REMU,    32'd7,         32'd100,       32'd7,         1'b0, 8'd32},
      '{DIVU,    32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 1'b0, 8'd32},
      '{DIVU,    32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, 8'd0},
      '{REMU,    32'd5,         32'd0,         32'd5,         1'b0, 8'd0},
      '{4'b0000, 32'd9,         32'd3,         32'd0,         1'b1, 8'd0},
      '{4'b1111, 32'd9,         32'd3,         32'd0,         1'b1, 8'd0},
      '{4'b1000, 32'd9,         32'd0,         32'd0,         1'b1, 8'd0}
   };

`ifdef MULDIV_SIGNED_EN
   localparam int NSGN = 10;
   vec_t sgn_tab [NSGN] = '{
      '{DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 8'd32},
      '{REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 8'd32},
      '{DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 8'd0},
      '{REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 8'd0},
      '{MULH, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 1'b0, 8'd32},
      '{MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 8'd32},
      '{DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 8'd32},
      '{REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         1'b0, 8'd32},
      '{DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, 8'd0},
      '{REM,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1'b0, 8'd0}
   };
`else
   localparam int NSGN = 3;
   vec_t sgn_tab [NSGN] = '{
      '{DIV,  32'hFFFF_FFF9, 32'd2, 32'd0, 1'b1, 8'd0},
      '{REM,  32'hFFFF_FFF9, 32'd2, 32'd0, 1'b1, 8'd0},
      '{MULH, 32'hFFFF_FFFE, 32'd3, 32'd0, 1'b1, 8'd0}
   };
`endif

   muldiv_unit #(.DATA_WIDTH(W), .OPCODE_LENGTH(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_a       (req_a),
      .req_b       (req_b),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_result (resp_result),
      .resp_err    (resp_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Monitor: pops the scoreboard on each response handshake.
   always @(negedge clk) begin
      if (!reset && resp_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got result %h err %b, expected no response", resp_result, resp_err);
         end else begin
            if (!seen) begin
               seen = 1'b1;
               chk("latency", 32'(cyc - int'(sb[0].acc)), 32'(sb[0].lat));
            end
            if (resp_ready) begin
               chk("result", resp_result, sb[0].res);
               chk("err", 32'(resp_err), 32'(sb[0].err));
               void'(sb.pop_front());
               seen = 1'b0;
            end
         end
      end
   end

   // Callers sit at posedge+#1; returns at posedge+#1 after the accept edge.
   task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] res, input logic err, input logic [7:0] lat, input bit track);
      bit accepted = 1'b0;
      int guard = 0;
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      while (!accepted && guard < 300) begin
         @(negedge clk);
         accepted = req_ready;
         @(posedge clk);
         #1;
         guard++;
      end
      req_valid = 1'b0;
      req_op    = MUL;
      req_a     = 32'hA5A5_5A5A;
      req_b     = 32'h1234_5678;
      chk("accept", 32'(accepted), 32'd1);
      if (accepted && track)
         sb.push_back('{res: res, err: err, lat: lat, acc: 32'(cyc)});
   endtask

   task automatic drain();
      int guard = 0;
      while (sb.size() != 0 && guard < 300) begin
         @(posedge clk);
         #1;
         guard++;
      end
      chk("drain", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      int guard;
      logic [W-1:0] held;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_result", resp_result, 32'd0);
      chk("rst_err", 32'(resp_err), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rel_req_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;

      for (int i = 0; i < NBASE; i++) begin
         send(base_tab[i].op, base_tab[i].a, base_tab[i].b, base_tab[i].res, base_tab[i].err, base_tab[i].lat, 1'b1);
         drain();
      end
      for (int i = 0; i < NSGN; i++) begin
         send(sgn_tab[i].op, sgn_tab[i].a, sgn_tab[i].b, sgn_tab[i].res, sgn_tab[i].err, sgn_tab[i].lat, 1'b1);
         drain();
      end

      // Response stall: result held and no new accept while resp_ready is low
      resp_ready = 1'b0;
      send(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 8'd32, 1'b1);
      guard = 0;
      @(negedge clk);
      while (!resp_valid && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      chk("stall_valid_seen", 32'(resp_valid), 32'd1);
      held = 32'hFFFF_FFFE;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_valid", 32'(resp_valid), 32'd1);
         chk("stall_result", resp_result, held);
         chk("stall_req_ready", 32'(req_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      resp_ready = 1'b1;
      drain();

      // Flush ten cycles into a MUL
      send(MUL, 32'd1000, 32'd1000, 32'd0, 1'b0, 8'd0, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_req_ready", 32'(req_ready), 32'd1);
      chk("flush_resp_valid", 32'(resp_valid), 32'd0);
      @(posedge clk);
      #1;
      send(MUL, 32'd3, 32'd4, 32'd12, 1'b0, 8'd32, 1'b1);
      drain();

      // Same scenario aborted by reset
      send(MUL, 32'd1000, 32'd1000, 32'd0, 1'b0, 8'd0, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("mid_rel_req_ready", 32'(req_ready), 32'd1);
      chk("mid_rel_resp_valid", 32'(resp_valid), 32'd0);
      chk("mid_rel_result", resp_result, 32'd0);
      @(posedge clk);
      #1;
      send(MUL, 32'd3, 32'd4, 32'd12, 1'b0, 8'd32, 1'b1);
      drain();

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end
endmodule
